// File: rtl/serial_sub_clk.sv
// serial_sub_clk -- digit-serial subtractor with borrow-in: d = a - b - bi (mod 2^WIDTH).
// Latency: N = WIDTH/DIGIT cycles from the accepted start edge to done/d valid.
// Backpressure: start is sampled only while idle; start during busy is dropped.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   a, b     in   WIDTH-bit minuend / subtrahend, captured on the accepted start edge
//   bi       in   borrow-in, captured on the accepted start edge
//   d        out  registered difference, updated only on completion
//   bo       out  registered borrow-out (1 when a < b + bi, unsigned)
//   ov       out  signed-overflow flag
//   busy     out  high while a subtraction is in progress
//   done     out  one-cycle completion pulse
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   : ov is registered at completion from the captured operand sign
//               bits and the result sign bit (borrow-in plays no part).
//   undefined : ov is a constant 0 and no sign-capture flops exist.
//
// WIDTH must be a multiple of DIGIT.

module serial_sub_clk #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  // Counter only has to reach N-1; keep at least one bit for N == 1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             busy_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // One digit of the subtraction.  Both digits are zero-extended by one bit so
  // that a negative digit result wraps and sets the extra top bit, which is
  // exactly the borrow into the next digit.
  // ---------------------------------------------------------------------------
  logic [DIGIT:0]   dig_diff;
  logic [DIGIT-1:0] digit_d;
  logic             borrow_d;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    dig_diff = {1'b0, a_sh_q[DIGIT-1:0]}
             - {1'b0, b_sh_q[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, borrow_q};
    digit_d  = dig_diff[DIGIT-1:0];
    borrow_d = dig_diff[DIGIT];
  end

  // The accumulator fills from the MSB side: after N shifts the first digit
  // computed (least significant) has walked down to bit 0.
  generate
    if (N > 1) begin : g_acc_shift
      always_comb acc_d = {digit_d, acc_q[WIDTH-1:DIGIT]};
    end else begin : g_acc_single
      always_comb acc_d = digit_d;
    end
  endgenerate

`ifdef SERIAL_SUB_OVF_EN
  logic a_sgn_q;
  logic b_sgn_q;
  logic ov_q;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.  The visible result registers (d, bo,
  // ov) are written only on the completion edge, so partial sums in acc_q
  // never reach the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      ov_q     <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse; only the completion branch re-asserts it.
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= bi;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            // Sign bits are shifted out of a_sh_q/b_sh_q during RUN, so keep
            // copies for the overflow decision at completion.
            a_sgn_q  <= a[WIDTH-1];
            b_sgn_q  <= b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          a_sh_q   <= a_sh_q >> DIGIT;
          b_sh_q   <= b_sh_q >> DIGIT;
          acc_q    <= acc_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);

          if (cnt_q == LAST_CNT) begin
            d_q     <= acc_d;
            bo_q    <= borrow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
            // The final digit carries the result sign bit in its MSB.
            // Overflow: operands of different sign, result sign differs from a.
            ov_q    <= (a_sgn_q != b_sgn_q) && (digit_d[DIGIT-1] != a_sgn_q);
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SERIAL_SUB_OVF_EN
  assign ov = ov_q;
`else
  assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_clk.sv
// tb_serial_sub_clk -- directed bench for serial_sub_clk at WIDTH=32, DIGIT=4 (N=8).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_serial_sub_clk;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic [31:0] d;
  logic        bo;
  logic        ov;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  serial_sub_clk #(.WIDTH(32), .DIGIT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bi      (bi),
    .d       (d),
    .bo      (bo),
    .ov      (ov),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive a start request at the current (falling-edge) time; returns one
  // falling edge later, i.e. just after the start edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic biv);
    a     = av;
    b     = bv;
    bi    = biv;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for done (bounded) starting from 'lat0' edges after the start edge,
  // then check latency, busy duration, output stability and the result.
  task automatic finish_op(input string tag, input int lat0,
                           input logic [31:0] ed, input logic ebo, input logic eov);
    int          lat;
    int          busy_cnt;
    logic        dchg;
    logic [31:0] d0;
    lat      = lat0;
    busy_cnt = 0;
    dchg     = 1'b0;
    d0       = d;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (d !== d0) dchg = 1'b1;
      @(negedge clock);
      lat++;
    end
    chk({tag, ".latency"},  lat,      32'd8);
    chk({tag, ".busy_len"}, busy_cnt, 32'(8 - lat0));
    chk({tag, ".d_stable"}, dchg,     32'd0);
    chk({tag, ".d"},        d,        ed);
    chk({tag, ".bo"},       bo,       ebo);
    chk({tag, ".ov"},       ov,       eov);
    chk({tag, ".busy_off"}, busy,     32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic biv, input logic [31:0] ed, input logic ebo,
                        input logic eov);
    @(negedge clock);
    issue(av, bv, biv);
    finish_op(tag, 0, ed, ebo, eov);
  endtask

  initial begin
    int done_seen;

    // ---- reset ----
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    bi      = 1'b0;
    #1;
    chk("rst.d",    d,    32'd0);
    chk("rst.bo",   bo,   32'd0);
    chk("rst.ov",   ov,   32'd0);
    chk("rst.busy", busy, 32'd0);
    chk("rst.done", done, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // ---- arithmetic vectors ----
    run_op("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    run_op("wrap",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("adder",  32'h48C0_EBA4, 32'h3561_4642, 1'b0, 32'h135F_A562, 1'b0, 1'b0);
    run_op("hi",     32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op("ovneg",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, OVF);
    run_op("borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("ovpos",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, OVF);

    // ---- start while busy is ignored ----
    @(negedge clock);
    issue(32'h0000_0010, 32'h0000_0003, 1'b0);   // edge count 0 after start
    repeat (2) @(negedge clock);                  // third RUN cycle
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0000;
    bi    = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finish_op("ignore", 3, 32'h0000_000D, 1'b0, 1'b0);

    // ---- start in the same cycle as done ----
    run_op("b2b1", 32'h0000_0020, 32'h0000_0001, 1'b0, 32'h0000_001F, 1'b0, 1'b0);
    chk("b2b.done_now", done, 32'd1);
    issue(32'h0000_0001, 32'h0000_0002, 1'b0);
    finish_op("b2b2", 0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // ---- reset during RUN ----
    @(negedge clock);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mrst.d",    d,    32'd0);
    chk("mrst.bo",   bo,   32'd0);
    chk("mrst.ov",   ov,   32'd0);
    chk("mrst.busy", busy, 32'd0);
    chk("mrst.done", done, 32'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("mrst.no_done", done_seen, 32'd0);

    // ---- operation after reset recovery ----
    run_op("post", 32'h0000_0009, 32'h0000_0002, 1'b1, 32'h0000_0006, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
